// File: rtl/add_to_acap_pkg.sv
// Shared sizes, types and the modular-reduction helper for the ACC update stage.
// Latency: n/a (compile-time constants and a combinational function only).
// Backpressure: n/a.
package add_to_acap_pkg;

    localparam int RING_SIZE     = 8;
    localparam int RING_DEPTH    = 3;
    localparam int DATA_SIZE_ARB = 8;
    localparam int PE_NUMBER     = 2;
    localparam int NTT_NUMBER    = 2;
    localparam int LWE_SIZE      = 2;
    localparam int D_R           = 2;
    localparam int A_WIDTH       = 4;
    localparam int Q             = 251;

    // Lanes per cycle, chunks per polynomial pair, and digit count.
    localparam int P = PE_NUMBER * NTT_NUMBER;
    localparam int W = (2 * RING_SIZE) / P;
    localparam int K = LWE_SIZE * D_R;

    localparam int SECRET_KEY_SIZE   = K * W;
    localparam int SECRET_ADDR_WIDTH = $clog2(SECRET_KEY_SIZE);

    localparam int BANK_W = $clog2(P);
    localparam int ROW_W  = $clog2(W);
    localparam int K_W    = $clog2(K);

    // Product is kept at full width; one extra bit absorbs the ACC addend.
    localparam int PROD_W = A_WIDTH + DATA_SIZE_ARB;
    localparam int SUM_W  = PROD_W + 1;

    // Cycles between a step's last issue and the next step's first issue.
    localparam int DRAIN_CYCLES = 4;
    localparam int DRAIN_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [DATA_SIZE_ARB-1:0]         coef_t;
    typedef logic [P-1:0][DATA_SIZE_ARB-1:0]  row_t;
    typedef logic [P-1:0][PROD_W-1:0]         prod_row_t;

    // Exact reduction into [0,Q); the constant divisor keeps this a fixed circuit.
    function automatic coef_t mod_q(input logic [SUM_W-1:0] x);
        logic [SUM_W-1:0] r;
        r = x % SUM_W'(Q);
        return coef_t'(r);
    endfunction

endpackage

// File: rtl/add_to_acap_if.sv
// Host load/readback, start/done and key-memory signals of the ACC update stage.
// Latency: n/a (wiring only).
// Backpressure: none; host writes are dropped by the block while it is busy.
interface add_to_acap_if;
    import add_to_acap_pkg::*;

    logic                          write_enable_bram;
    logic [RING_DEPTH:0]           write_addr_input;
    logic [DATA_SIZE_ARB-1:0]      data_in;
    logic                          load_a;
    logic [DATA_SIZE_ARB-1:0]      data_a;
    logic [RING_DEPTH-1:0]         write_addr_a;
    logic                          start_addToACAP;
    logic [DATA_SIZE_ARB*P-1:0]    secret_key;
    logic [RING_DEPTH:0]           read_out;
    logic                          done;
    logic [DATA_SIZE_ARB-1:0]      data_out;
    logic [SECRET_ADDR_WIDTH-1:0]  secret_addr;

    modport slave (
        input  write_enable_bram, write_addr_input, data_in,
        input  load_a, data_a, write_addr_a,
        input  start_addToACAP, secret_key, read_out,
        output done, data_out, secret_addr
    );

    modport master (
        output write_enable_bram, write_addr_input, data_in,
        output load_a, data_a, write_addr_a,
        output start_addToACAP, secret_key, read_out,
        input  done, data_out, secret_addr
    );

endinterface

// File: rtl/add_to_acap_shift_reg.sv
// Fixed-depth delay line used to line up control and data with the key stream.
// Latency: SHIFT cycles from din to dout.
// Backpressure: none; advances every cycle, cleared by reset.
module add_to_acap_shift_reg #(
    parameter int SHIFT = 1,
    parameter int DATA  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DATA-1:0] din,
    output logic [DATA-1:0] dout
);

    logic [DATA-1:0] stage_q [SHIFT];

    // Shift one stage per cycle; reset empties the line so no stale write fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SHIFT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < SHIFT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[SHIFT-1];

endmodule

// File: rtl/add_to_acap.sv
// ACC <- ACC + a_k*key_k mod Q over all K digits, P coefficients per cycle.
// Latency: K*(W+4)+1 cycles start->done; readback 1 cycle; key read 2 cycles.
// Backpressure: none; host writes and start are ignored while a run is active.
module add_to_acap
    import add_to_acap_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    add_to_acap_if.slave  bus
);

    state_t                state;
    logic [K_W-1:0]        k_q;
    logic [ROW_W-1:0]      c_q;
    logic [DRAIN_W-1:0]    drain_cnt;

    logic issue;
    logic host_ok;
    logic rst;

    assign issue   = (state == ST_ISSUE);
    assign host_ok = (state == ST_IDLE) || (state == ST_DONE);
    assign rst     = ~resetn;

    // Sequencer: W issue cycles per digit, then a drain so writes land before re-reading.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            k_q             <= '0;
            c_q             <= '0;
            drain_cnt       <= '0;
            bus.done        <= 1'b0;
            bus.secret_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_addToACAP) begin
                        state <= ST_ISSUE;
                        k_q   <= '0;
                        c_q   <= '0;
                    end
                end
                ST_ISSUE: begin
                    bus.secret_addr <= SECRET_ADDR_WIDTH'(k_q) * SECRET_ADDR_WIDTH'(W)
                                     + SECRET_ADDR_WIDTH'(c_q);
                    c_q <= c_q + 1'b1;
                    if (c_q == ROW_W'(W - 1)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        c_q <= '0;
                        if (k_q == K_W'(K - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            k_q   <= k_q + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.start_addToACAP) begin
                        bus.done <= 1'b0;
                        state    <= ST_ISSUE;
                        k_q      <= '0;
                        c_q      <= '0;
                    end else begin
                        bus.done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage: P banks side by side, so one row holds coefficients row*P .. row*P+P-1.
    row_t                 acc_mem [W];
    logic [A_WIDTH-1:0]   a_mem   [RING_SIZE];
    row_t                 rd_row;

    logic [BANK_W-1:0]    h_bank;
    logic [ROW_W-1:0]     h_row;
    logic [BANK_W-1:0]    rb_bank;
    logic [ROW_W-1:0]     rb_row;

    assign h_bank  = bus.write_addr_input[BANK_W-1:0];
    assign h_row   = ROW_W'(bus.write_addr_input >> BANK_W);
    assign rb_bank = bus.read_out[BANK_W-1:0];
    assign rb_row  = ROW_W'(bus.read_out >> BANK_W);

    // Only the low A_WIDTH bits of a digit are meaningful.
    logic unused_data_a_hi;
    assign unused_data_a_hi = ^bus.data_a[DATA_SIZE_ARB-1:A_WIDTH];

    logic                 wb_vld;
    logic [ROW_W-1:0]     wb_row;
    row_t                 wb_dat;

    // a-vector host port; frozen while a run is using it.
    always_ff @(posedge clk) begin
        if (host_ok && bus.load_a) begin
            a_mem[bus.write_addr_a] <= bus.data_a[A_WIDTH-1:0];
        end
    end

    // ACC array: row read for the issuing chunk, pipeline write-back, host write when idle.
    always_ff @(posedge clk) begin
        rd_row <= acc_mem[c_q];
        if (wb_vld) begin
            acc_mem[wb_row] <= wb_dat;
        end else if (host_ok && bus.write_enable_bram) begin
            acc_mem[h_row][h_bank] <= bus.data_in;
        end
    end

    // Readback port, one cycle from read_out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.data_out <= '0;
        end else begin
            bus.data_out <= acc_mem[rb_row][rb_bank];
        end
    end

    // Alignment: everything issued at edge t must meet the key word valid in cycle t+2.
    logic [A_WIDTH-1:0] a_d;
    row_t               row_d;

    add_to_acap_shift_reg #(.SHIFT(3), .DATA(A_WIDTH)) u_a_dly (
        .clk   (clk),
        .reset (rst),
        .din   (a_mem[RING_DEPTH'(k_q)]),
        .dout  (a_d)
    );

    // rd_row is already one register past the issue edge.
    add_to_acap_shift_reg #(.SHIFT(2), .DATA(DATA_SIZE_ARB * P)) u_row_dly (
        .clk   (clk),
        .reset (rst),
        .din   (rd_row),
        .dout  (row_d)
    );

    add_to_acap_shift_reg #(.SHIFT(4), .DATA(ROW_W + 1)) u_ctl_dly (
        .clk   (clk),
        .reset (rst),
        .din   ({issue, c_q}),
        .dout  ({wb_vld, wb_row})
    );

    row_t       key_row;
    row_t       base_q;
    prod_row_t  prod_q;

    assign key_row = bus.secret_key;

    // Product stage: full-width a_k*key per lane, ACC operand carried alongside.
    always_ff @(posedge clk) begin
        base_q <= row_d;
        for (int i = 0; i < P; i++) begin
            prod_q[i] <= PROD_W'(a_d) * PROD_W'(key_row[i]);
        end
    end

    // Reduce ACC + product into [0,Q) for the write-back.
    always_comb begin
        wb_dat = '0;
        for (int i = 0; i < P; i++) begin
            wb_dat[i] = mod_q(SUM_W'(base_q[i]) + SUM_W'(prod_q[i]));
        end
    end

endmodule

// File: tb/tb_add_to_acap.sv
// Randomised bench for add_to_acap against a plain-arithmetic ACC model.
// Latency: drives one host write per cycle, checks done latency and key address sweep.
// Backpressure: none; key memory modelled with a fixed 2-cycle read.
module tb_add_to_acap;
    import add_to_acap_pkg::*;

    localparam int N2  = 2 * RING_SIZE;
    localparam int LAT = K * (W + DRAIN_CYCLES) + 1;
    localparam int AW  = RING_DEPTH + 1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    add_to_acap_if bus ();

    add_to_acap dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // Key ROM: address register then registered data.
    logic [DATA_SIZE_ARB*P-1:0]   key_mem [SECRET_KEY_SIZE];
    logic [SECRET_ADDR_WIDTH-1:0] key_addr_q;

    always @(posedge clk) begin
        key_addr_q     <= bus.secret_addr;
        bus.secret_key <= key_mem[key_addr_q];
    end

    int acc_m [N2];
    int a_m   [K];
    int key_m [K][N2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack key_k coefficients c*P..c*P+P-1 into word k*W+c, lane i at bits i*D.
    task automatic build_key_mem();
        logic [DATA_SIZE_ARB*P-1:0] word;
        for (int k = 0; k < K; k++) begin
            for (int c = 0; c < W; c++) begin
                word = '0;
                for (int i = 0; i < P; i++) begin
                    word[i*DATA_SIZE_ARB +: DATA_SIZE_ARB] = DATA_SIZE_ARB'(key_m[k][c*P+i]);
                end
                key_mem[k*W+c] = word;
            end
        end
    endtask

    task automatic model_run();
        for (int k = 0; k < K; k++) begin
            for (int j = 0; j < N2; j++) begin
                acc_m[j] = (acc_m[j] + a_m[k] * key_m[k][j]) % Q;
            end
        end
    endtask

    task automatic load_host();
        for (int j = 0; j < N2; j++) begin
            bus.write_enable_bram = 1'b1;
            bus.write_addr_input  = AW'(j);
            bus.data_in           = DATA_SIZE_ARB'(acc_m[j]);
            tick();
        end
        bus.write_enable_bram = 1'b0;
        for (int k = 0; k < K; k++) begin
            bus.load_a       = 1'b1;
            bus.write_addr_a = RING_DEPTH'(k);
            // Upper bits are junk the block must drop.
            bus.data_a       = DATA_SIZE_ARB'(($urandom_range(15, 0) << A_WIDTH) | a_m[k]);
            tick();
        end
        bus.load_a = 1'b0;
        build_key_mem();
    endtask

    task automatic readback(input string tag);
        for (int j = 0; j < N2; j++) begin
            bus.read_out = AW'(j);
            tick();
            chk(tag, int'(bus.data_out), acc_m[j]);
        end
    endtask

    task automatic run_job(input bit chk_addr, input bit poke);
        int cyc;
        int m;
        int exp_a;
        bus.start_addToACAP = 1'b1;
        tick();
        bus.start_addToACAP = 1'b0;
        chk("done_clr", int'(bus.done), 0);
        for (cyc = 1; cyc <= LAT + 20; cyc++) begin
            tick();
            bus.write_enable_bram = 1'b0;
            bus.load_a            = 1'b0;
            bus.start_addToACAP   = 1'b0;
            if (chk_addr && cyc <= K * (W + DRAIN_CYCLES)) begin
                m     = cyc - 1;
                exp_a = (m / (W + DRAIN_CYCLES)) * W;
                exp_a = exp_a + (((m % (W + DRAIN_CYCLES)) < W) ? (m % (W + DRAIN_CYCLES)) : (W - 1));
                chk("addr", int'(bus.secret_addr), exp_a);
            end
            if (poke && cyc == 5) begin
                bus.write_enable_bram = 1'b1;
                bus.write_addr_input  = '0;
                bus.data_in           = DATA_SIZE_ARB'(acc_m[0] ^ 'h5a);
                bus.load_a            = 1'b1;
                bus.write_addr_a      = RING_DEPTH'(K - 1);
                bus.data_a            = DATA_SIZE_ARB'(a_m[K-1] ^ 1);
            end
            if (poke && cyc == 8) bus.start_addToACAP = 1'b1;
            if (bus.done) break;
        end
        bus.write_enable_bram = 1'b0;
        bus.load_a            = 1'b0;
        bus.start_addToACAP   = 1'b0;
        chk("done_lat", cyc, LAT);
        chk("addr_hold", int'(bus.secret_addr), K * W - 1);
        model_run();
    endtask

    task automatic rand_key(input int kmin);
        for (int k = kmin; k < K; k++)
            for (int j = 0; j < N2; j++) key_m[k][j] = int'($urandom_range(255, 0));
    endtask

    initial begin
        bus.write_enable_bram = 1'b0;
        bus.write_addr_input  = '0;
        bus.data_in           = '0;
        bus.load_a            = 1'b0;
        bus.data_a            = '0;
        bus.write_addr_a      = '0;
        bus.start_addToACAP   = 1'b0;
        bus.read_out          = '0;

        tick();
        tick();
        chk("rst_done", int'(bus.done), 0);
        chk("rst_dout", int'(bus.data_out), 0);
        chk("rst_addr", int'(bus.secret_addr), 0);
        resetn = 1'b1;
        tick();

        // All-ones: each coefficient ends at K mod Q.
        for (int j = 0; j < N2; j++) acc_m[j] = 0;
        for (int k = 0; k < K; k++) begin
            a_m[k] = 1;
            for (int j = 0; j < N2; j++) key_m[k][j] = 1;
        end
        load_host();
        run_job(1'b0, 1'b0);
        readback("ones");
        chk("ones_val", acc_m[0], K % Q);

        // Zero digits: ACC must come back unchanged, key addresses sweep in order.
        for (int j = 0; j < N2; j++) acc_m[j] = int'($urandom_range(255, 0));
        for (int k = 0; k < K; k++) a_m[k] = 0;
        rand_key(0);
        load_host();
        run_job(1'b1, 1'b0);
        readback("zero");

        // Single step with wrap: 5 + 3*(Q-1) mod Q = 2.
        for (int j = 0; j < N2; j++) begin
            acc_m[j]    = 5;
            key_m[0][j] = Q - 1;
        end
        a_m[0] = 3;
        for (int k = 1; k < K; k++) a_m[k] = 0;
        rand_key(1);
        load_host();
        run_job(1'b0, 1'b0);
        readback("wrap");

        // Random runs with host writes and a start pulse while busy.
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < N2; j++) acc_m[j] = int'($urandom_range(255, 0));
            for (int k = 0; k < K; k++) a_m[k] = int'($urandom_range(15, 1));
            rand_key(0);
            load_host();
            run_job(1'b1, 1'b1);
            readback("rand");
        end

        // Reset mid-run, then a clean run from fresh contents.
        bus.start_addToACAP = 1'b1;
        tick();
        bus.start_addToACAP = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        resetn = 1'b0;
        #1;
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_addr", int'(bus.secret_addr), 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_done", int'(bus.done), 0);
        for (int j = 0; j < N2; j++) acc_m[j] = int'($urandom_range(255, 0));
        for (int k = 0; k < K; k++) a_m[k] = int'($urandom_range(15, 0));
        rand_key(0);
        load_host();
        run_job(1'b1, 1'b0);
        readback("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
